// File: rtl/rf_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu_ctrl_pkg
// Description : Shared opcodes, FSM state encoding and width defaults for the
//               register-file ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_alu_ctrl_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_LI  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rf_alu_ctrl_alu.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu
// Description : Purely combinational ALU. Produces the result, the carry or
//               borrow, and a flag saying whether the carry flag should update.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_alu
    import rf_alu_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] res,
    output logic          carry_out,
    output logic          carry_we
);

    logic [DW:0] w_sum;
    logic        w_lt;

    assign w_sum = {1'b0, op_a} + {1'b0, op_b};
    assign w_lt  = (op_a < op_b);

    // Opcode decode; only ADD/SUB touch the carry flag
    always_comb begin
        res       = '0;
        carry_out = 1'b0;
        carry_we  = 1'b0;
        case (op)
            OP_ADD: begin
                res       = w_sum[DW-1:0];
                carry_out = w_sum[DW];
                carry_we  = 1'b1;
            end
            OP_SUB: begin
                res       = op_a - op_b;
                carry_out = w_lt;
                carry_we  = 1'b1;
            end
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_SLT:  res = {{(DW-1){1'b0}}, w_lt};
            OP_SLL:  res = op_a << op_b[2:0];
            OP_LI:   res = imm;
            default: res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rf_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_alu_ctrl
// Description : Four-state sequencer (IDLE/READ/EXEC/WRITE) that reads two
//               registers, runs the ALU and writes the result back.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_alu_ctrl
    import rf_alu_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [DW-1:0] in_imm,
    output logic [AW-1:0] RX,
    output logic [AW-1:0] RY,
    input  logic [DW-1:0] busX,
    input  logic [DW-1:0] busY,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] busW,
    output logic          WEN,
    output logic          done,
    output logic          carry
);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [AW-1:0] rx_q, rx_d;
    logic [AW-1:0] ry_q, ry_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] res_q, res_d;
    logic          carry_q, carry_d;
    logic [AW-1:0] rw_q, rw_d;

    logic [DW-1:0] w_alu_res;
    logic          w_alu_cout;
    logic          w_alu_cwe;

    rf_alu #(.DW(DW)) u_alu (
        .op        (op_q),
        .op_a      (opa_q),
        .op_b      (opb_q),
        .imm       (imm_q),
        .res       (w_alu_res),
        .carry_out (w_alu_cout),
        .carry_we  (w_alu_cwe)
    );

    // Next-state and datapath-capture logic; read addresses are latched at
    // accept so they are already stable for the whole READ cycle
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        rw_d    = rw_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    rd_d    = in_rd;
                    imm_d   = in_imm;
                    rx_d    = in_rs;
                    ry_d    = in_rt;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                opa_d   = busX;
                opb_d   = busY;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = w_alu_res;
                if (w_alu_cwe) begin
                    carry_d = w_alu_cout;
                end
                rw_d    = rd_q;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            rw_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            rw_q    <= rw_d;
        end
    end

    // Handshake and write strobes decode straight from state, so an async
    // reset during WRITE drops WEN before the file can commit
    assign in_ready = (state_q == S_IDLE);
    assign done     = (state_q == S_WRITE);
    assign WEN      = (state_q == S_WRITE) && (rw_q != '0);
    assign RX       = rx_q;
    assign RY       = ry_q;
    assign RW       = rw_q;
    assign busW     = res_q;
    assign carry    = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_alu_ctrl
// Description : Closed-loop bench: sequencer plus behavioural 8x8 register
//               file, reference model and write-back scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_alu_ctrl;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, LI = 3'd7;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [2:0] in_rd = '0, in_rs = '0, in_rt = '0;
    logic [7:0] in_imm = '0;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW;
    logic       WEN, done, carry;

    rf_alu_ctrl #(.DW(8), .AW(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm(in_imm), .RX(RX), .RY(RY), .busX(busX), .busY(busY),
        .RW(RW), .busW(busW), .WEN(WEN), .done(done), .carry(carry)
    );

    always #5 Clk = ~Clk;

    // Behavioural register file: r0 reads zero, synchronous write
    logic [7:0] rf [8];
    initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
    assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];
    always @(posedge Clk) if (WEN && RW != 3'd0) rf[RW] <= busW;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        logic       carry;
        logic       wen;
        int         acc_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_rf [8];
    logic       exp_carry;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         prev_acc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Write-back monitor: every done pulse pops one expected result
    always @(negedge Clk) begin
        if (Rst_n) begin
            check("wen_outside_write", {31'd0, WEN & ~done}, 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_rw",      {29'd0, RW},   {29'd0, e.rd});
                    check("wb_busw",    {24'd0, busW}, {24'd0, e.data});
                    check("wb_wen",     {31'd0, WEN},  {31'd0, e.wen});
                    check("wb_carry",   {31'd0, carry}, {31'd0, e.carry});
                    check("wb_latency", cyc - e.acc_cyc, 32'd3);
                end
            end
        end
    end

    // Drive one instruction, wait (bounded) for acceptance, model it.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt,
                         input logic [7:0] imm, input bit keep_valid,
                         input bit check_gap);
        int         t;
        logic [7:0] a, b, r;
        logic [8:0] s;
        logic       c;
        exp_t       e;
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge Clk);
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        if (check_gap) check("accept_spacing", cyc - prev_acc, 32'd4);
        prev_acc = cyc;
        a = (rs == 3'd0) ? 8'h00 : exp_rf[rs];
        b = (rt == 3'd0) ? 8'h00 : exp_rf[rt];
        c = exp_carry;
        case (op)
            ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            SUB:  begin r = a - b; c = (a < b); end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            SLT:  r = (a < b) ? 8'h01 : 8'h00;
            SLL:  r = a << b[2:0];
            default: r = imm;
        endcase
        exp_carry = c;
        if (rd != 3'd0) exp_rf[rd] = r;
        e.rd = rd; e.data = r; e.carry = c; e.wen = (rd != 3'd0); e.acc_cyc = cyc;
        sb.push_back(e);
        @(negedge Clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_rf[i] = 8'h00;
        exp_carry = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wen",      {31'd0, WEN},      32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_carry",    {31'd0, carry},    32'd0);
        check("rst_rx",       {29'd0, RX},       32'd0);
        check("rst_rw",       {29'd0, RW},       32'd0);
        check("rst_busw",     {24'd0, busW},     32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        issue(LI,  3'd1, 3'd0, 3'd0, 8'h7F, 0, 0);
        issue(LI,  3'd2, 3'd0, 3'd0, 8'h81, 0, 0);
        issue(ADD, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(SUB, 3'd4, 3'd2, 3'd1, 8'h00, 0, 0);
        issue(SUB, 3'd5, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(SLT, 3'd6, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(LI,  3'd6, 3'd0, 3'd0, 8'h0B, 0, 0);
        issue(SLL, 3'd7, 3'd1, 3'd6, 8'h00, 0, 0);
        issue(LI,  3'd1, 3'd0, 3'd0, 8'hF0, 0, 0);
        issue(LI,  3'd2, 3'd0, 3'd0, 8'h3C, 0, 0);
        issue(AND_, 3'd3, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(OR_,  3'd4, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(XOR_, 3'd5, 3'd1, 3'd2, 8'h00, 0, 0);
        issue(LI,  3'd0, 3'd0, 3'd0, 8'hAA, 0, 0);
        issue(ADD, 3'd6, 3'd0, 3'd0, 8'h00, 0, 0);

        // Continuous valid: dependent chain, one accept every 4 cycles
        issue(LI,  3'd1, 3'd0, 3'd0, 8'h05, 1, 0);
        issue(ADD, 3'd2, 3'd1, 3'd1, 8'h00, 1, 1);
        issue(ADD, 3'd3, 3'd2, 3'd1, 8'h00, 0, 1);
        repeat (4) @(negedge Clk);

        // Reset in the middle of EXEC of an ADD to r3
        issue(ADD, 3'd3, 3'd1, 3'd1, 8'h00, 0, 0);
        void'(sb.pop_back());
        exp_rf[3] = 8'h0F;
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_wen",      {31'd0, WEN},      32'd0);
        check("midrst_carry",    {31'd0, carry},    32'd0);
        exp_carry = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("midrst_r3", {24'd0, rf[3]}, 32'h0F);
        issue(LI, 3'd7, 3'd0, 3'd0, 8'h55, 0, 0);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge Clk);
        check("sb_drained", sb.size(), 32'd0);
        @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rf_r%0d", i), {24'd0, rf[i]}, {24'd0, exp_rf[i]});
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_alu_ctrl.md
# rf_alu_ctrl

Sequencer that acts as the initiator for the 8-entry × 8-bit register file (write port RW/busW/WEN, read ports RX/busX and RY/busY). It does the following for each accepted instruction:
- reads two source registers;
- computes an ALU result;
- writes the result back through the file's synchronous write port.

It sits between an instruction source with a valid/ready handshake and the register file. It processes one instruction at a time.

## Interface
Parameters:
- DW, 8, data width; matches register file word width.
- AW, 3, register address width (2^AW registers; register 0 reads as zero and is never written).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (unsigned), 6 SLL, 7 LI.
- in_rd  in  AW  destination register.
- in_rs  in  AW  source X register.
- in_rt  in  AW  source Y register.
- in_imm  in  DW  immediate, used only by LI.
- RX  out  AW  read address X to register file.
- RY  out  AW  read address Y to register file.
- busX  in  DW  read data X (combinational from file).
- busY  in  DW  read data Y (combinational from file).
- RW  out  AW  write address.
- busW  out  DW  write data.
- WEN  out  1  write enable.
- done  out  1  one-cycle pulse in the write-back cycle.
- carry  out  1  carry/borrow flag of last ADD/SUB, held until next ADD/SUB.

## Operation
- The FSM has four states: IDLE → READ → EXEC → WRITE → IDLE. It uses one-hot or binary encoding; the encoding is not externally visible.
- **IDLE:**
  - in_ready=1.
  - On in_valid=1, latch op/rd/rs/rt/imm and go to READ.
  - in_ready=0 in every other state. Inputs there are ignored.
- **READ:**
  - RX=latched rs, RY=latched rt.
  - Capture busX→opA and busY→opB at the clock edge.
  - Go to EXEC.
- **EXEC:**
  - Compute the result into the result register, with these widths and rules:
  - ADD: {carry,res}=opA+opB, DW+1 bits.
  - SUB: res=opA−opB mod 2^DW; carry=1 iff opA<opB (borrow).
  - AND/OR/XOR: bitwise.
  - SLT: res=1 if opA<opB unsigned, else 0.
  - SLL: res=opA<<opB[2:0]; zero fill.
  - LI: res=imm.
  - carry updates only on ADD/SUB.
  - Go to WRITE.
- **WRITE:**
  - RW=rd, busW=result, done=1.
  - WEN=1 iff rd≠0. When rd=0, done still pulses and no write occurs.
  - Go to IDLE.
- Outside READ, RX/RY hold their last values. Outside WRITE, WEN=0 and done=0. RW/busW hold their last values.
- Reading register 0 returns whatever busX/busY present; the file guarantees zero.
- **Reset (async, any state):**
  - FSM→IDLE, in_ready=1.
  - WEN=0, done=0, carry=0.
  - RX=RY=RW=0, busW=0, opA=opB=result=0.
  - An in-flight instruction is dropped with no write. A reset asserted during WRITE before the edge prevents the write, because WEN falls asynchronously.

## Timing
- Instruction accepted at edge E0 (in_valid & in_ready).
- READ occupies cycle E0→E1.
- EXEC occupies cycle E1→E2.
- WRITE occupies cycle E2→E3. The register file commits at E3.
- Latency from accept to committed write: 3 cycles. Throughput: 1 instruction per 4 cycles.
- in_ready rises in the cycle after E3. A new instruction can be accepted at E4.
- A back-to-back dependent instruction (rs = previous rd) reads the committed value with no forwarding, because its READ follows the E3 commit.
- All outputs are registered or decoded directly from state. There is no combinational path from in_* to register-file outputs.

## Structure
- A shared package holds:
  - opcode localparams OP_ADD..OP_LI;
  - state encoding S_IDLE/S_READ/S_EXEC/S_WRITE;
  - DW/AW defaults.
- One natural sub-module is rf_alu: purely combinational, (op, opA, opB, imm) → (res, carry_out, carry_we). The controller holds the FSM and registers.
- The bench instantiates rf_alu_ctrl together with the existing register file to close the loop.

## Test plan
- Reset then LI rd=1 imm=0x7F, LI rd=2 imm=0x81, ADD rd=3 rs=1 rt=2 → r3=0x00, carry=1; WEN high exactly in the third cycle after each accept.
- SUB rd=4 rs=2 rt=1 → r4=0x02, carry=0; SUB rd=5 rs=1 rt=2 → r5=0xFE, carry=1; SLT rd=6 rs=1 rt=2 → r6=0x01.
- SLL rd=7 rs=1 rt=x where the rt register holds 0x0B → shift amount 3, r7=0xF8; AND/OR/XOR of 0xF0,0x3C → 0x30/0xFC/0xCC.
- LI rd=0 imm=0xAA → done pulses, WEN stays 0, busX on RX=0 still reads 0x00.
- Hold in_valid high continuously with 3 instructions → exactly one accept per 4 cycles, in_ready low in READ/EXEC/WRITE, the dependent chain gives correct results.
- Assert Rst_n low mid-EXEC of an ADD to r3 → no write to r3, carry=0, in_ready=1 immediately; the next instruction after release completes normally.
